// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment patterns, converter state type and sizing helpers for seg7_mux_driver.
package seg7_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} cvt_state_t;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b1111110;
  localparam logic [6:0] SEG_DIGITS [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
    return nibble > 4'd9 ? SEG_BLANK : SEG_DIGITS[nibble];
  endfunction
  // ceil(w*log10(2)) decimal digits plus one spare nibble for the add-3 headroom
  function automatic int bcd_nibbles(input int w);
    return (w * 30103 + 99999) / 100000 + 1;
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter, one shift per clock.
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int DATA_W = 14,
  parameter int BCD_W = 4 * bcd_nibbles(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] bin,
  output logic              busy,
  output logic              done,
  output logic [BCD_W-1:0]  bcd
);
  localparam int CW = $clog2(DATA_W + 1);
  cvt_state_t state, state_nx;
  logic [DATA_W-1:0] sr;
  logic [BCD_W-1:0] adj;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (start ? SHIFT : IDLE) :
               state == SHIFT ? (cnt == CW'(1) ? COMMIT : SHIFT) : IDLE;
  always_comb begin
    busy = state != IDLE;
    done = state == COMMIT;
  end
  always_comb begin
    adj = bcd;
    for (int i = 0; i < BCD_W / 4; i++)
      adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sr <= '0;
      bcd <= '0;
      cnt <= '0;
    end else if (state == IDLE && start) begin
      sr <= bin;
      bcd <= '0;
      cnt <= CW'(DATA_W);
    end else if (state == SHIFT) begin
      {bcd, sr} <= {adj, sr} << 1;
      cnt <= cnt - CW'(1);
    end
endmodule

// File: rtl/seg7_mux_driver.sv
// seg7_mux_driver: binary value to multiplexed common-anode 7-segment display via sequential BCD.
// Build option LEADING_ZERO_BLANK_EN blanks digits above the most-significant nonzero digit.
module seg7_mux_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W = 14,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     value,
  input  logic                  load,
  output logic                  busy,
  output logic                  overflow,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an
);
  localparam int NB = bcd_nibbles(DATA_W);
  localparam int DN = NB > NUM_DIGITS ? NB : NUM_DIGITS;
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic done, lz;
  logic [4*NB-1:0] bcd;
  logic [4*DN-1:0] bcd_ext;
  logic [4*NUM_DIGITS-1:0] disp;
  logic [PW-1:0] presc;
  logic [IW-1:0] idx;
  logic [6:0] seg_nx;
  bin2bcd_seq #(.DATA_W(DATA_W), .BCD_W(4 * NB)) u_cvt (
    .clk(clk), .rst(rst), .start(load), .bin(value),
    .busy(busy), .done(done), .bcd(bcd)
  );
  assign bcd_ext = (4*DN)'(bcd);
`ifdef LEADING_ZERO_BLANK_EN
  assign lz = idx != '0 && (disp >> (4 * idx)) == '0;
`else
  assign lz = 1'b0;
`endif
  always_comb
    seg_nx = overflow ? SEG_DASH : lz ? SEG_BLANK : bcd_to_seg(disp[4*idx +: 4]);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      disp <= '0;
      overflow <= 1'b0;
    end else if (done) begin
      disp <= bcd_ext[4*NUM_DIGITS-1:0];
      overflow <= |(bcd_ext >> (4 * NUM_DIGITS));
    end
  // seg and an share one register stage so a digit and its enable change together
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      presc <= '0;
      idx <= '0;
      seg <= SEG_BLANK;
      an <= '1;
    end else begin
      presc <= presc == PW'(REFRESH_DIV - 1) ? '0 : presc + PW'(1);
      if (presc == PW'(REFRESH_DIV - 1))
        idx <= idx == IW'(NUM_DIGITS - 1) ? '0 : idx + IW'(1);
      seg <= seg_nx;
      an <= ~(NUM_DIGITS'(1) << idx);
    end
endmodule

// File: tb/tb_seg7_mux_driver.sv
// tb_seg7_mux_driver: randomized and directed checks of seg7_mux_driver against a decimal display model.
module tb_seg7_mux_driver;
  localparam int ND = 4;
  localparam int DW = 14;
  localparam int RD = 4;
  logic clk, rst, load, busy, overflow;
  logic [DW-1:0] value;
  logic [6:0] seg;
  logic [ND-1:0] an;
  int nvec = 0, nerr = 0, exp_val = 0;

  seg7_mux_driver #(.NUM_DIGITS(ND), .DATA_W(DW), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load),
    .busy(busy), .overflow(overflow), .seg(seg), .an(an)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] digit_pat(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      default: return 7'b0000100;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input int i);
    int p = 1, lim = 1;
    for (int j = 0; j < i; j++) p *= 10;
    for (int j = 0; j < ND; j++) lim *= 10;
    if (v >= lim) return 7'b1111110;
`ifdef LEADING_ZERO_BLANK_EN
    if (i > 0 && v < p) return 7'b1111111;
`endif
    return digit_pat((v / p) % 10);
  endfunction

  function automatic int an_idx();
    for (int i = 0; i < ND; i++)
      if (an === ~(ND'(1) << i)) return i;
    return -1;
  endfunction

  task automatic scan_check();
    int prev = -1, run = 0, k;
    bit full = 0;
    repeat (2 * ND * RD + 2) begin
      @(negedge clk);
      k = an_idx();
      check("an_onehot", k >= 0, 1);
      if (k >= 0) check($sformatf("seg_d%0d_v%0d", k, exp_val), seg, exp_seg(exp_val, k));
      if (k == prev) run++;
      else begin
        if (prev >= 0) check("an_next", k, (prev + 1) % ND);
        if (full) check("dwell", run, RD);
        full = prev >= 0;
        prev = k;
        run = 1;
      end
    end
  endtask

  task automatic do_load(input int v, input int second);
    int n = 0, k;
    @(negedge clk);
    value = DW'(v);
    load = 1;
    @(negedge clk);
    load = 0;
    while (busy === 1'b1 && n < 200) begin
      if (n == 1 && second >= 0) begin
        value = DW'(second);
        load = 1;
      end else load = 0;
      k = an_idx();
      if (k >= 0) check("hold_old", seg, exp_seg(exp_val, k));
      n++;
      @(negedge clk);
    end
    load = 0;
    check("busy_cycles", n, DW + 1);
    exp_val = v;
    check("overflow", overflow, v >= 10000);
    scan_check();
  endtask

  initial begin
    rst = 0;
    load = 0;
    value = '0;
    #3 rst = 1;
    #1;
    check("rst_seg", seg, 7'h7F);
    check("rst_an", an, 4'hF);
    check("rst_busy", busy, 0);
    check("rst_ovf", overflow, 0);
    @(negedge clk);
    rst = 0;
    exp_val = 0;
    scan_check();
    do_load(1234, -1);
    do_load(12000, -1);
    do_load(9999, -1);
    do_load(42, 7777);
    do_load(0, -1);
    do_load(10000, -1);
    do_load(16383, -1);
    @(negedge clk);
    value = DW'(5555);
    load = 1;
    @(negedge clk);
    load = 0;
    repeat (5) @(posedge clk);
    #2 rst = 1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_seg", seg, 7'h7F);
    check("abort_an", an, 4'hF);
    check("abort_ovf", overflow, 0);
    @(negedge clk);
    rst = 0;
    exp_val = 0;
    scan_check();
    do_load(5, -1);
    repeat (12) do_load(int'($urandom_range(0, 16383)), -1);
    repeat (4) do_load(int'($urandom_range(0, 99)), -1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
